// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StIdle,
    StRun
  } fetch_state_e;

  localparam int unsigned PC_STEP   = 4;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order skid buffer holding fetched {instruction, pc} pairs for decode.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [N-1:0]     push_inst,
  input  logic [N-1:0]     push_pc,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [N-1:0]     inst,
  output logic [N-1:0]     inst_pc,
  output logic             inst_valid
);

  logic [CNT_W-1:0] count_q;
  logic [N-1:0]     head_inst_q, head_pc_q;
  logic [N-1:0]     tail_inst_q, tail_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      head_inst_q <= '0;
      head_pc_q   <= '0;
      tail_inst_q <= '0;
      tail_pc_q   <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == '0) begin
            head_inst_q <= push_inst;
            head_pc_q   <= push_pc;
          end else begin
            tail_inst_q <= push_inst;
            tail_pc_q   <= push_pc;
          end
          count_q <= count_q + CNT_W'(1);
        end
        2'b01: begin
          head_inst_q <= tail_inst_q;
          head_pc_q   <= tail_pc_q;
          count_q     <= count_q - CNT_W'(1);
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (count_q == CNT_W'(1)) begin
            head_inst_q <= push_inst;
            head_pc_q   <= push_pc;
          end else begin
            head_inst_q <= tail_inst_q;
            head_pc_q   <= tail_pc_q;
            tail_inst_q <= push_inst;
            tail_pc_q   <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = count_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? head_inst_q : '0;
  assign inst_pc    = inst_valid ? head_pc_q : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, tracks the one-cycle memory latency and feeds decode
// through a two-entry skid buffer, with redirect/flush and a fetch-enable pause.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned  N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  output logic [N-1:0] mem_adr,
  input  logic [N-1:0] mem_data,
  output logic [N-1:0] inst,
  output logic [N-1:0] inst_pc,
  output logic         inst_valid,
  input  logic         inst_ready,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc
);

  fetch_state_e     state_q;
  logic [N-1:0]     issue_pc_q;
  logic [N-1:0]     inflight_pc_q;
  logic             inflight_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   demand;
  logic             pop, push, issue;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pop  = inst_valid & inst_ready;
  assign push = inflight_q & ~redirect_valid;

  // Occupancy the buffer would have after this edge if nothing new were issued.
  assign demand = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign issue  = (state_q == StRun) && !redirect_valid &&
                  (demand < (CNT_W + 1)'(BUF_DEPTH));

  assign mem_adr = issue_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      issue_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      unique case (state_q)
        StBoot:  state_q <= fetch_en ? StRun : StIdle;
        StRun:   if (!fetch_en) state_q <= StIdle;
        StIdle:  if (fetch_en) state_q <= StRun;
        default: state_q <= StBoot;
      endcase

      if (redirect_valid) begin
        // The word returning next cycle belongs to the old path and is dropped.
        inflight_q <= 1'b0;
        issue_pc_q <= {redirect_pc[N-1:2], 2'b00};
      end else if (issue) begin
        inflight_q    <= 1'b1;
        inflight_pc_q <= issue_pc_q;
        issue_pc_q    <= issue_pc_q + N'(PC_STEP);
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

  fetch_buf #(
    .N(N)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_inst (mem_data),
    .push_pc   (inflight_pc_q),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_valid(inst_valid)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a randomized run
// scored against an in-order expected PC stream.
module tb_inst_fetch_unit;

  localparam int unsigned N = 32;

  logic         clk;
  logic         rst_n, fetch_en, inst_ready, redirect_valid;
  logic [N-1:0] redirect_pc, mem_adr, mem_data, inst, inst_pc;
  logic         inst_valid;
  logic [N-1:0] w_mem_adr, w_mem_data, w_inst, w_inst_pc;
  logic         w_inst_valid;

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] exp_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] mem_word(input logic [N-1:0] adr);
    return 32'h100 + (adr >> 2);
  endfunction

  // One-cycle synchronous read memory for both instances.
  always @(posedge clk) begin
    mem_data   <= mem_word(mem_adr);
    w_mem_data <= mem_word(w_mem_adr);
  end

  inst_fetch_unit #(.N(N), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .mem_adr       (mem_adr),
    .mem_data      (mem_data),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  inst_fetch_unit #(.N(N), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (1'b1),
    .mem_adr       (w_mem_adr),
    .mem_data      (w_mem_data),
    .inst          (w_inst),
    .inst_pc       (w_inst_pc),
    .inst_valid    (w_inst_valid),
    .inst_ready    (1'b1),
    .redirect_valid(1'b0),
    .redirect_pc   (32'h0)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) cyc();
    checks++;
    if ({inst_valid, inst, inst_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b inst=%h pc=%h, want all 0",
               inst_valid, inst, inst_pc);
    end
    checks++;
    if (mem_adr !== 32'h0) begin
      errors++; $display("FAIL reset_adr: got %h, want 00000000", mem_adr);
    end
    checks++;
    if (w_mem_adr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL reset_adr_wrap: got %h, want fffffffc", w_mem_adr);
    end
  endtask

  task automatic test_stream();
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++;
      if (inst_valid !== (k == 3)) begin
        errors++;
        $display("FAIL first_valid_latency: cycle %0d got valid=%b, want %b", k, inst_valid, k == 3);
      end
    end
    exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      checks++;
      if (inst_valid !== 1'b1) begin
        errors++; $display("FAIL stream_gap: beat %0d got valid=%b, want 1", i, inst_valid);
      end
      if (inst_valid && inst_ready) begin
        checks++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL stream_order: got pc=%h inst=%h, want pc=%h inst=%h",
                   inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] held_inst, held_pc, held_adr;
    cyc();
    inst_ready = 1'b0;
    held_inst = inst; held_pc = inst_pc; held_adr = mem_adr;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) cyc();
      checks++;
      if (!inst_valid || inst !== held_inst || inst_pc !== held_pc || mem_adr !== held_adr) begin
        errors++;
        $display("FAIL stall_hold: s=%0d got valid=%b inst=%h pc=%h adr=%h, want 1/%h/%h/%h",
                 s, inst_valid, inst, inst_pc, mem_adr, held_inst, held_pc, held_adr);
      end
    end
    checks++;
    if (dut.count !== 2'd2 || dut.inflight_q !== 1'b0) begin
      errors++;
      $display("FAIL stall_occupancy: got count=%0d inflight=%b, want 2/0", dut.count, dut.inflight_q);
    end
    cyc();
    inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      if (inst_valid && inst_ready) begin
        checks++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL bp_resume_order: got pc=%h inst=%h, want pc=%h inst=%h",
                   inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
      end
    end
  endtask

  task automatic test_redirect();
    cyc(); inst_ready = 1'b0;
    cyc(); cyc();
    checks++;
    if (dut.count !== 2'd2) begin
      errors++; $display("FAIL redirect_precond: got count=%0d, want 2", dut.count);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h5B;
    cyc();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_flush: got valid=%b, want 0", inst_valid);
    end
    cyc();
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_gap: got valid=%b, want 0", inst_valid);
    end
    cyc();
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h116 || inst_pc !== 32'h58) begin
      errors++;
      $display("FAIL redirect_target: got valid=%b inst=%h pc=%h, want 1/00000116/00000058",
               inst_valid, inst, inst_pc);
    end
    exp_pc = 32'h58;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      if (inst_valid && inst_ready) begin
        checks++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL redirect_path: got pc=%h inst=%h, want pc=%h inst=%h",
                   inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
      end
    end
  endtask

  task automatic test_pause();
    logic [N-1:0] adr_ref;
    int n_del;
    n_del = 0; adr_ref = '0;
    cyc();
    fetch_en = 1'b0;
    for (int p = 0; p < 5; p++) begin
      if (p > 0) cyc();
      if (p == 1) adr_ref = mem_adr;
      if (p > 1) begin
        checks++;
        if (mem_adr !== adr_ref) begin
          errors++; $display("FAIL pause_adr: p=%0d got %h, want %h", p, mem_adr, adr_ref);
        end
      end
      if (inst_valid && inst_ready) begin
        n_del++;
        checks++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL pause_order: got pc=%h inst=%h, want pc=%h", inst_pc, inst, exp_pc);
        end
        exp_pc += 4;
      end
    end
    checks++;
    if (n_del != 3) begin
      errors++; $display("FAIL pause_drain: got %0d deliveries, want 3", n_del);
    end
    cyc();
    fetch_en = 1'b1;
    n_del = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc();
      if (inst_valid && inst_ready) begin
        n_del++;
        checks++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL pause_resume: got pc=%h inst=%h, want pc=%h", inst_pc, inst, exp_pc);
        end
        exp_pc += 4;
      end
    end
    checks++;
    if (n_del < 5) begin
      errors++; $display("FAIL pause_restart: got %0d deliveries, want >= 5", n_del);
    end
  endtask

  task automatic test_midreset();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({inst_valid, inst, inst_pc} !== '0 || mem_adr !== 32'h0 || w_mem_adr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL async_reset: got valid=%b inst=%h pc=%h adr=%h wadr=%h, want 0/0/0/0/fffffffc",
               inst_valid, inst, inst_pc, mem_adr, w_mem_adr);
    end
    #2 rst_n = 1'b1;
    repeat (3) cyc();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h100) begin
      errors++;
      $display("FAIL reset_restart: got valid=%b pc=%h inst=%h, want 1/00000000/00000100",
               inst_valid, inst_pc, inst);
    end
  endtask

  task automatic test_wrap();
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    repeat (3) cyc();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC || w_inst !== 32'h4000_00FF) begin
      errors++;
      $display("FAIL wrap_first: got valid=%b pc=%h inst=%h, want 1/fffffffc/400000ff",
               w_inst_valid, w_inst_pc, w_inst);
    end
    cyc();
    checks++;
    if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'h0 || w_inst !== 32'h100) begin
      errors++;
      $display("FAIL wrap_second: got valid=%b pc=%h inst=%h, want 1/00000000/00000100",
               w_inst_valid, w_inst_pc, w_inst);
    end
  endtask

  task automatic test_random();
    logic         prev_stall;
    logic [N-1:0] prev_inst, prev_pc;
    int           n_del;
    cyc(); rst_n = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    cyc(); rst_n = 1'b1;
    exp_pc = 32'h0; prev_stall = 1'b0; prev_inst = '0; prev_pc = '0; n_del = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      fetch_en       = ($urandom_range(0, 9) != 0);
      inst_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = $urandom_range(0, 4095);
      if (prev_stall) begin
        checks++;
        if (!inst_valid || inst !== prev_inst || inst_pc !== prev_pc) begin
          errors++;
          $display("FAIL rand_hold: got valid=%b inst=%h pc=%h, want 1/%h/%h",
                   inst_valid, inst, inst_pc, prev_inst, prev_pc);
        end
      end
      if (inst_valid && inst_ready) begin
        n_del++;
        checks++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL rand_order: got pc=%h inst=%h, want pc=%h inst=%h",
                   inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 4;
      end
      if (redirect_valid) exp_pc = {redirect_pc[N-1:2], 2'b00};
      prev_stall = inst_valid && !inst_ready && !redirect_valid;
      prev_inst  = inst;
      prev_pc    = inst_pc;
    end
    checks++;
    if (n_del < 500) begin
      errors++; $display("FAIL rand_progress: got %0d deliveries, want >= 500", n_del);
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_pause();
    test_midreset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Requester side of the instruction memory: owns the PC and drives the word-aligned byte address to the memory.
- Tracks the memory's fixed one-cycle synchronous read latency and buffers returned words in a 2-entry skid buffer.
- Hands instructions to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, and a fetch-enable pause.

Parameters:
- N, 32, datapath/address width.
- RESET_PC, 0, byte address of the first fetch after reset.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  when high, new fetches may issue.
- mem_adr  out  N  byte address to instruction memory; equals issue_pc.
- mem_data  in  N  memory read data, valid the cycle after the address was sampled.
- inst  out  N  instruction at buffer head.
- inst_pc  out  N  byte PC of inst.
- inst_valid  out  1  buffer head holds a valid instruction.
- inst_ready  in  1  decode accepts inst this cycle.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  N  new fetch byte address; bits [1:0] ignored and treated as 00.

Behaviour:
- Reset (async, while rst_n=0):
  - state=BOOT, issue_pc=RESET_PC, inflight=0, inflight_pc=0.
  - Buffer empty; inst=0, inst_pc=0, inst_valid=0.
  - mem_adr follows issue_pc, so it reads RESET_PC.
  - Mid-operation reset discards everything immediately.
- FSM:
  - BOOT: no issue; on the next edge go to RUN if fetch_en=1, else IDLE.
  - RUN: issues when allowed; fetch_en=0 moves to IDLE.
  - IDLE: no issue; fetch_en=1 moves to RUN.
  - Redirect does not change state.
- Addressing:
  - mem_adr = issue_pc combinationally.
  - The memory samples mem_adr at each posedge, and mem_data is valid in the following cycle.
- Issue condition: state==RUN and !redirect_valid and (count + inflight - pop) < 2.
  - count = buffer occupancy (0..2).
  - pop = inst_valid & inst_ready.
- On issue:
  - inflight<=1, inflight_pc<=issue_pc.
  - issue_pc<=issue_pc+4, modulo 2^N (wraps 0xFFFFFFFC->0 at N=32).
  - With no issue, inflight<=0 and issue_pc holds.
- Return: in any cycle with inflight=1 and !redirect_valid, {mem_data, inflight_pc} is pushed into the buffer at the edge. The issue rule guarantees no overflow.
- Buffer:
  - 2-entry FIFO; head drives inst/inst_pc.
  - inst_valid = (count!=0), registered state.
  - Push and pop in the same cycle are both honoured; order is preserved.
  - While valid, inst and inst_pc hold until popped.
- Redirect (cycle t):
  - A handshake in cycle t counts as accepted.
  - At the edge: buffer cleared, inflight<=0 (the return in t+1 is discarded), issue_pc<={redirect_pc[N-1:2],2'b00}.
  - inst_valid=0 in t+1; first redirect fetch issues in t+1; its inst_valid rises in t+3.
  - Back-to-back redirects: the last one wins.
- fetch_en low:
  - No new issues; the outstanding inflight word still lands in the buffer.
  - Buffered words stay deliverable.
- Latency and throughput:
  - First inst_valid is in the 3rd cycle after rst_n rises (BOOT, issue, return, valid).
  - Steady state is 1 instruction/cycle with inst_ready=1.
- Backpressure: with inst_ready=0, at most 2 buffered + 0 inflight; issue_pc and mem_adr hold stable.

Decomposition:
- fetch_pkg:
  - state encoding BOOT/IDLE/RUN.
  - PC_STEP=4.
  - BUF_DEPTH=2.
- One sub-module, fetch_buf: 2-entry FIFO of {inst, pc} with push/pop/flush/count, instantiated once.
- FSM, PC and inflight tracking stay in the top.

Test Plan:
- Stream: memory model mem[i]=0x100+i, RESET_PC=0, fetch_en=1, inst_ready=1.
  - Required: inst_valid rises 3 cycles after reset release.
  - Then inst/inst_pc = 0x100/0, 0x101/4, 0x102/8 on consecutive cycles, with no gaps.
- Backpressure: drop inst_ready for 4 cycles mid-stream.
  - During the stall: count reaches 2, mem_adr stays constant, inst holds its value.
  - After release: consecutive PCs continue, with no lost or duplicated word.
- Redirect: assert redirect_valid with redirect_pc=0x5B while 2 words are buffered.
  - inst_valid=0 the next cycle.
  - 3 cycles after redirect, inst=0x116 and inst_pc=0x58.
  - No old-path PC appears afterwards.
- Pause: drop fetch_en for 5 cycles while streaming.
  - The inflight word still delivers and mem_adr stops advancing.
  - After re-enable, the PC sequence resumes without a gap.
- Reset mid-stream: pull rst_n low asynchronously, between clock edges.
  - inst_valid/inst/inst_pc go to 0 and mem_adr goes to RESET_PC without waiting for a clock edge.
  - After release, the sequence restarts at PC 0.
- Wrap: RESET_PC=0xFFFFFFFC.
  - First two delivered inst_pc are 0xFFFFFFFC, then 0x00000000.
